// File: rtl/auth_msg_receiver.sv
// Byte-serial authentication message receiver: parses bare or USB-framed
// messages into setup fields, a 32-bit header and a bounded payload buffer.
module auth_msg_receiver #(
  parameter int MAX_PAYLOAD_BYTES = 64,
  parameter int CNT_W             = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           usb_mode,
  input  logic [7:0]                     byte_in,
  input  logic                           byte_valid,
  input  logic                           byte_last,
  output logic                           byte_ready,
  output logic                           msg_valid,
  input  logic                           msg_ack,
  output logic [7:0]                     bmRequestType,
  output logic [7:0]                     bRequest,
  output logic [15:0]                    wLength,
  output logic [31:0]                    header,
  output logic [MAX_PAYLOAD_BYTES*8-1:0] payload,
  output logic [CNT_W-1:0]               payload_len,
  output logic [7:0]                     pending_auth_request,
  output logic                           err_truncated,
  output logic                           err_overflow,
  output logic                           err_length,
  output logic                           err_version
);

  typedef enum logic [6:0] {
    IDLE    = 7'b0000001,
    SETUP   = 7'b0000010,
    HEADER  = 7'b0000100,
    WLEN    = 7'b0001000,
    PAYLOAD = 7'b0010000,
    DRAIN   = 7'b0100000,
    DONE    = 7'b1000000
  } state_t;

  localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(MAX_PAYLOAD_BYTES);

  state_t     state;
  logic       usb_q;
  logic [1:0] hdr_cnt;
  logic       wlen_cnt;
  logic       accept;

  assign byte_ready = (state != DONE);
  assign accept     = byte_valid & byte_ready;

  // Only meaningful while a message is held; derived from stable field registers.
  assign pending_auth_request = msg_valid ?
    {header[9:8], (header[23] ? 2'b10 : 2'b01), 1'b0, usb_q, header[17:16]} : 8'h00;

  function automatic logic len_err(input logic u, input logic [CNT_W-1:0] len,
                                   input logic [15:0] wl);
    return u && (32'(len) != 32'(wl));
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      usb_q         <= 1'b0;
      hdr_cnt       <= 2'd0;
      wlen_cnt      <= 1'b0;
      msg_valid     <= 1'b0;
      err_truncated <= 1'b0;
      err_overflow  <= 1'b0;
      err_length    <= 1'b0;
      err_version   <= 1'b0;
      payload_len   <= '0;
      header        <= '0;
      bmRequestType <= '0;
      bRequest      <= '0;
      wLength       <= '0;
      payload       <= '0;
    end else if (accept) begin
      case (state)
        IDLE: begin
          usb_q <= usb_mode;
          if (usb_mode) begin
            bmRequestType <= byte_in;
            state         <= SETUP;
          end else begin
            header[31:24] <= byte_in;
            hdr_cnt       <= 2'd1;
            state         <= HEADER;
          end
          if (byte_last) begin
            err_truncated <= 1'b1;
            err_length    <= len_err(usb_mode, payload_len, wLength);
            msg_valid     <= 1'b1;
            state         <= DONE;
          end
        end
        SETUP: begin
          bRequest <= byte_in;
          state    <= HEADER;
          if (byte_last) begin
            err_truncated <= 1'b1;
            err_length    <= len_err(usb_q, payload_len, wLength);
            msg_valid     <= 1'b1;
            state         <= DONE;
          end
        end
        HEADER: begin
          case (hdr_cnt)
            2'd0:    header[31:24] <= byte_in;
            2'd1:    header[23:16] <= byte_in;
            2'd2:    header[15:8]  <= byte_in;
            default: header[7:0]   <= byte_in;
          endcase
          hdr_cnt <= hdr_cnt + 2'd1;
          if (hdr_cnt == 2'd3) begin
            err_version <= (header[31:24] != 8'h01);
            state       <= usb_q ? WLEN : PAYLOAD;
          end
          // A USB frame ending right after the header still lacks wLength.
          if (byte_last) begin
            err_truncated <= (hdr_cnt != 2'd3) || usb_q;
            err_length    <= len_err(usb_q, payload_len, wLength);
            msg_valid     <= 1'b1;
            state         <= DONE;
          end
        end
        WLEN: begin
          if (!wlen_cnt) begin
            wLength[7:0] <= byte_in;
            wlen_cnt     <= 1'b1;
            if (byte_last) begin
              err_truncated <= 1'b1;
              err_length    <= len_err(usb_q, payload_len, {wLength[15:8], byte_in});
              msg_valid     <= 1'b1;
              state         <= DONE;
            end
          end else begin
            wLength[15:8] <= byte_in;
            wlen_cnt      <= 1'b0;
            state         <= PAYLOAD;
            if (byte_last) begin
              err_length <= len_err(usb_q, payload_len, {byte_in, wLength[7:0]});
              msg_valid  <= 1'b1;
              state      <= DONE;
            end
          end
        end
        PAYLOAD: begin
          if (payload_len == MAX_LEN) begin
            err_overflow <= 1'b1;
            msg_valid    <= byte_last;
            state        <= byte_last ? DONE : DRAIN;
          end else begin
            for (int k = 0; k < MAX_PAYLOAD_BYTES; k++)
              if (payload_len == CNT_W'(k)) payload[8*k +: 8] <= byte_in;
            payload_len <= payload_len + 1'b1;
            if (byte_last) begin
              err_length <= len_err(usb_q, payload_len + 1'b1, wLength);
              msg_valid  <= 1'b1;
              state      <= DONE;
            end
          end
        end
        DRAIN: begin
          if (byte_last) begin
            msg_valid <= 1'b1;
            state     <= DONE;
          end
        end
        default: ;
      endcase
    end else if (state == DONE && msg_ack) begin
      state         <= IDLE;
      msg_valid     <= 1'b0;
      err_truncated <= 1'b0;
      err_overflow  <= 1'b0;
      err_length    <= 1'b0;
      err_version   <= 1'b0;
      payload_len   <= '0;
      hdr_cnt       <= 2'd0;
      wlen_cnt      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_auth_msg_receiver.sv
// Directed bench for auth_msg_receiver with hand-computed expectations.
module tb_auth_msg_receiver;
  localparam int MAXB  = 4;
  localparam int CNT_W = 16;

  logic clk = 1'b0, reset = 1'b0;
  logic usb_mode = 1'b0, byte_valid = 1'b0, byte_last = 1'b0, msg_ack = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic byte_ready, msg_valid;
  logic [7:0] bmRequestType, bRequest, pending_auth_request;
  logic [15:0] wLength;
  logic [31:0] header;
  logic [MAXB*8-1:0] payload;
  logic [CNT_W-1:0] payload_len;
  logic err_truncated, err_overflow, err_length, err_version;
  logic [3:0] errs;
  assign errs = {err_truncated, err_overflow, err_length, err_version};

  auth_msg_receiver #(.MAX_PAYLOAD_BYTES(MAXB), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .usb_mode(usb_mode), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_last(byte_last), .byte_ready(byte_ready),
    .msg_valid(msg_valid), .msg_ack(msg_ack), .bmRequestType(bmRequestType),
    .bRequest(bRequest), .wLength(wLength), .header(header), .payload(payload),
    .payload_len(payload_len), .pending_auth_request(pending_auth_request),
    .err_truncated(err_truncated), .err_overflow(err_overflow),
    .err_length(err_length), .err_version(err_version)
  );

  always #5 clk = ~clk;

  int n_run = 0, n_fail = 0;
  logic [7:0] q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives q byte by byte from negedges; ends on the negedge after the final byte.
  task automatic send(input logic usb, input logic with_last);
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      usb_mode   = usb;
      byte_valid = 1'b1;
      byte_in    = q[i];
      byte_last  = with_last && (i == q.size() - 1);
      chk("rdy_during_msg", byte_ready, 1);
      @(posedge clk);
    end
    @(negedge clk);
    byte_valid = 1'b0;
    byte_last  = 1'b0;
  endtask

  task automatic ack();
    @(negedge clk);
    msg_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    msg_ack = 1'b0;
    chk("ack_mv", msg_valid, 0);
    chk("ack_rdy", byte_ready, 1);
    chk("ack_len", payload_len, 0);
    chk("ack_errs", errs, 0);
    chk("ack_par", pending_auth_request, 0);
  endtask

  initial begin
    #1;
    chk("rst_mv", msg_valid, 0);
    chk("rst_rdy", byte_ready, 1);
    chk("rst_hdr", header, 0);
    chk("rst_len", payload_len, 0);
    chk("rst_par", pending_auth_request, 0);
    chk("rst_errs", errs, 0);
    #22 reset = 1'b1;

    // msg_ack while idle must be ignored
    @(negedge clk); msg_ack = 1'b1;
    @(negedge clk); msg_ack = 1'b0;
    chk("idle_ack_rdy", byte_ready, 1);

    // bare framing
    q = '{8'h01, 8'h81, 8'h02, 8'h00, 8'hAA, 8'hBB};
    send(1'b0, 1'b1);
    chk("bare_mv", msg_valid, 1);
    chk("bare_hdr", header, 32'h01810200);
    chk("bare_len", payload_len, 2);
    chk("bare_pl", payload[15:0], 16'hBBAA);
    chk("bare_par", pending_auth_request, 8'hA1);
    chk("bare_errs", errs, 0);

    // handshake: ack withheld
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("hold_rdy", byte_ready, 0);
      chk("hold_mv", msg_valid, 1);
      chk("hold_hdr", header, 32'h01810200);
      chk("hold_par", pending_auth_request, 8'hA1);
    end
    ack();
    chk("ack_hdr_kept", header, 32'h01810200);

    // USB framing
    q = '{8'h21, 8'h0A, 8'h01, 8'h01, 8'h00, 8'h00, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33};
    send(1'b1, 1'b1);
    chk("usb_mv", msg_valid, 1);
    chk("usb_bm", bmRequestType, 8'h21);
    chk("usb_breq", bRequest, 8'h0A);
    chk("usb_wlen", wLength, 3);
    chk("usb_len", payload_len, 3);
    chk("usb_pl", payload[23:0], 24'h332211);
    chk("usb_par", pending_auth_request, 8'h15);
    chk("usb_errs", errs, 0);
    ack();

    // length mismatch
    q = '{8'h21, 8'h0A, 8'h01, 8'h01, 8'h00, 8'h00, 8'h04, 8'h00, 8'h11, 8'h22};
    send(1'b1, 1'b1);
    chk("lenerr_mv", msg_valid, 1);
    chk("lenerr_len", payload_len, 2);
    chk("lenerr_errs", errs, 4'b0010);
    ack();

    // USB, wLength=0, last on the high length byte
    q = '{8'h80, 8'h06, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send(1'b1, 1'b1);
    chk("wl0_mv", msg_valid, 1);
    chk("wl0_len", payload_len, 0);
    chk("wl0_par", pending_auth_request, 8'h14);
    chk("wl0_errs", errs, 0);
    ack();

    // overflow: 6 payload bytes into a 4-byte buffer
    q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    send(1'b0, 1'b1);
    chk("ovf_mv", msg_valid, 1);
    chk("ovf_len", payload_len, 4);
    chk("ovf_pl", payload, 32'h13121110);
    chk("ovf_errs", errs, 4'b0100);
    chk("ovf_par", pending_auth_request, 8'hD2);
    ack();

    // bad protocol version
    q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h55};
    send(1'b0, 1'b1);
    chk("ver_mv", msg_valid, 1);
    chk("ver_len", payload_len, 1);
    chk("ver_errs", errs, 4'b0001);
    ack();

    // truncated header
    q = '{8'h01, 8'h81};
    send(1'b0, 1'b1);
    chk("trunc_mv", msg_valid, 1);
    chk("trunc_errs", errs, 4'b1000);
    ack();

    // reset mid-payload, observed before any clock edge
    q = '{8'h01, 8'h81, 8'h02, 8'h00, 8'hAA};
    send(1'b0, 1'b0);
    #1 reset = 1'b0;
    #1;
    chk("mrst_mv", msg_valid, 0);
    chk("mrst_rdy", byte_ready, 1);
    chk("mrst_hdr", header, 0);
    chk("mrst_pl", payload, 0);
    chk("mrst_len", payload_len, 0);
    chk("mrst_wlen", {bmRequestType, bRequest, wLength}, 0);
    chk("mrst_errs", errs, 0);
    chk("mrst_par", pending_auth_request, 0);
    #1 reset = 1'b1;

    // next byte after reset starts a fresh message
    q = '{8'h01, 8'h81, 8'h02, 8'h00, 8'hCC};
    send(1'b0, 1'b1);
    chk("post_mv", msg_valid, 1);
    chk("post_hdr", header, 32'h01810200);
    chk("post_len", payload_len, 1);
    chk("post_pl", payload[7:0], 8'hCC);
    chk("post_errs", errs, 0);
    ack();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
